// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice: fetch FSM states,
// the (instr, pc4) word carried through the pipeline, and PC alignment.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_word_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched word that arrived while the
// IF/ID slot was full and stalled.
module fetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t d,
  output logic        valid,
  output fetch_word_t q
);

  logic        valid_q, valid_d;
  fetch_word_t word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (clear) begin
      valid_d = 1'b0;
      word_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      word_d  = d;
    end
  end

  // NOTE: a single entry is cheap to reset, so the data is cleared along with
  // valid; a deeper buffer would reset only its valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid = valid_q;
  assign q     = word_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, IF/ID output slot with a
// one-entry skid for stalls, and redirect handling that drains an in-flight request.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc4_q, if_pc4_d;

  logic            skid_load, skid_clear, skid_valid;
  fetch_word_t     skid_d, skid_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_tgt;
  logic            slot_accepts;
  logic            transfer;

  assign pc_plus4     = pc_q + PC_STEP;
  assign redirect_tgt = align_pc(redirect_pc);
  assign slot_accepts = !if_valid_q || !stall;
  assign transfer     = if_valid_q && !stall;

  fetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_d     = '{instr: imem_data, pc4: pc_plus4};

    if (transfer) if_valid_d = 1'b0;

    if (redirect) begin
      // Flush everything; an unacked request must still complete at its old address.
      if_valid_d = 1'b0;
      skid_clear = 1'b1;
      if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack) begin
        pend_pc_d = redirect_tgt;
        state_d   = ST_DRAIN;
      end else begin
        pc_d    = redirect_tgt;
        state_d = ST_REQ;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (slot_accepts) begin
              if_instr_d = imem_data;
              if_pc4_d   = pc_plus4;
              if_valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid) begin
            if_instr_d = skid_q.instr;
            if_pc4_d   = skid_q.pc4;
            if_valid_d = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            pc_d    = pend_pc_q;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP;
      if_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
    end
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    imem_addr = pc_q;
    if_valid  = if_valid_q;
    if_instr  = if_instr_q;
    if_pc4    = if_pc4_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model (expected fetch address and word queue).
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words fetched but not yet taken by IF/ID, the address the
  // fetcher should be requesting, and a pending redirect target while draining.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_addr;
  logic [31:0] m_pend;
  logic        m_drain;
  logic        m_idle;

  logic [31:0] seen_pc4[$];
  logic [31:0] seen_instr[$];

  task automatic model_reset();
    mq.delete();
    m_addr  = TB_RESET_PC;
    m_pend  = '0;
    m_drain = 1'b0;
    m_idle  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_data   = '0;
    model_reset();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b expected 0", imem_req); end
    checks++;
    if (imem_addr !== TB_RESET_PC) begin errors++; $display("FAIL rst_imem_addr: got %h expected %h", imem_addr, TB_RESET_PC); end
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
    checks++;
    if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h expected 0", if_instr); end
    checks++;
    if (if_pc4 !== 32'h0) begin errors++; $display("FAIL rst_if_pc4: got %h expected 0", if_pc4); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model at negedge, drive inputs, then
  // advance the model with what happens at the following rising edge.
  task automatic step(input logic st, input logic want_ack, input logic rd,
                      input logic [31:0] rpc, input logic [31:0] data);
    logic exp_req, exp_val, ack_l;
    @(negedge clk);
    exp_req = m_idle ? 1'b0 : (mq.size() < 2);
    exp_val = (mq.size() != 0);
    checks++;
    if (imem_req !== exp_req) begin
      errors++; $display("FAIL imem_req: got %b expected %b at %0t", imem_req, exp_req, $time);
    end
    checks++;
    if (if_valid !== exp_val) begin
      errors++; $display("FAIL if_valid: got %b expected %b at %0t", if_valid, exp_val, $time);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== m_addr) begin
        errors++; $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr, m_addr, $time);
      end
    end
    if (exp_val) begin
      checks++;
      if (if_instr !== mq[0].instr) begin
        errors++; $display("FAIL if_instr: got %h expected %h at %0t", if_instr, mq[0].instr, $time);
      end
      checks++;
      if (if_pc4 !== mq[0].pc4) begin
        errors++; $display("FAIL if_pc4: got %h expected %h at %0t", if_pc4, mq[0].pc4, $time);
      end
    end
    if (if_valid === 1'b1 && !st) begin
      seen_pc4.push_back(if_pc4);
      seen_instr.push_back(if_instr);
    end

    ack_l       = want_ack && (imem_req === 1'b1);
    stall       = st;
    imem_ack    = ack_l;
    imem_data   = data;
    redirect    = rd;
    redirect_pc = rpc;

    @(posedge clk);
    m_idle = 1'b0;
    if (exp_val && !st) void'(mq.pop_front());
    if (rd) begin
      mq.delete();
      if (exp_req && !ack_l) begin
        m_drain = 1'b1;
        m_pend  = rpc & 32'hFFFF_FFFC;
      end else begin
        m_drain = 1'b0;
        m_addr  = rpc & 32'hFFFF_FFFC;
      end
    end else if (exp_req && ack_l) begin
      if (m_drain) begin
        m_drain = 1'b0;
        m_addr  = m_pend;
      end else begin
        mq.push_back('{instr: data, pc4: m_addr + 32'd4});
        m_addr = m_addr + 32'd4;
      end
    end
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL req_after_release: got %b expected 1", imem_req); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    seen_pc4.delete(); seen_instr.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0, 32'h2008_0005);
    checks++;
    if (seen_pc4.size() != 5) begin
      errors++; $display("FAIL b2b_count: got %0d expected 5", seen_pc4.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen_pc4[i] !== 32'(4 * (i + 1)) || seen_instr[i] !== 32'h2008_0005) begin
          errors++; $display("FAIL b2b_word%0d: got %h/%h expected %h/20080005",
                             i, seen_pc4[i], seen_instr[i], 32'(4 * (i + 1)));
        end
      end
    end
  endtask

  task automatic test_wait_ack();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    seen_pc4.delete(); seen_instr.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
        errors++; $display("FAIL wait_addr%0d: got %h/%b expected 00000004/1", i, imem_addr, imem_req);
      end
    end
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (seen_pc4.size() != 2 || seen_pc4[0] !== 32'h4 || seen_pc4[1] !== 32'h8) begin
      errors++; $display("FAIL wait_seq: got %0d words expected 2 (pc4 4,8)", seen_pc4.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    seen_pc4.delete(); seen_instr.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, $urandom);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", imem_req); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, $urandom);
    checks++;
    if (seen_pc4.size() != 3 || seen_pc4[0] !== 32'h4 || seen_pc4[1] !== 32'h8 || seen_pc4[2] !== 32'hC) begin
      errors++; $display("FAIL stall_seq: got %0d words expected 3 (pc4 4,8,C)", seen_pc4.size());
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, $urandom);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h103, '0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
      errors++; $display("FAIL drain_hold: got req %b addr %h valid %b expected 1/00000010/0",
                         imem_req, imem_addr, if_valid);
    end
    step(1'b0, 1'b1, 1'b0, '0, 32'hBAD0_BAD0);
    checks++;
    if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      errors++; $display("FAIL drain_target: got addr %h valid %b expected 00000100/0", imem_addr, if_valid);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 32'h1234_5678);
    checks++;
    if (if_valid !== 1'b1 || if_pc4 !== 32'h104 || if_instr !== 32'h1234_5678) begin
      errors++; $display("FAIL drain_first: got %b/%h/%h expected 1/00000104/12345678",
                         if_valid, if_pc4, if_instr);
    end
  endtask

  task automatic test_redirect_skid();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    step(1'b1, 1'b1, 1'b0, '0, $urandom);
    step(1'b1, 1'b1, 1'b0, '0, $urandom);
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc4 !== 32'h4) begin
      errors++; $display("FAIL skid_full: got %b/%b/%h expected 0/1/00000004", imem_req, if_valid, if_pc4);
    end
    step(1'b1, 1'b0, 1'b1, 32'h40, '0);
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL skid_redirect: got %b/%b/%h expected 0/1/00000040", if_valid, imem_req, imem_addr);
    end
    seen_pc4.delete(); seen_instr.delete();
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    checks++;
    if (seen_pc4.size() != 1 || seen_pc4[0] !== 32'h44) begin
      errors++; $display("FAIL skid_cleared: got %0d words expected 1 (pc4 44)", seen_pc4.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, '0);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got %h expected FFFFFFFC", imem_addr);
    end
    step(1'b0, 1'b1, 1'b0, '0, 32'hCAFE_0001);
    checks++;
    if (if_valid !== 1'b1 || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4: got %b/%h/%h expected 1/00000000/00000000", if_valid, if_pc4, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== TB_RESET_PC || if_valid !== 1'b0 ||
        if_instr !== 32'h0 || if_pc4 !== 32'h0) begin
      errors++; $display("FAIL async_reset: got req %b addr %h valid %b instr %h pc4 %h expected all zero",
                         imem_req, imem_addr, if_valid, if_instr, if_pc4);
    end
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, $urandom);
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 7, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_ack();
    test_stall();
    test_redirect_drain();
    test_redirect_skid();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
